// File: rtl/decoder_scan_nx2n.sv
// Registered N-to-2^N one-hot decoder with an auto-scan mode that walks the
// asserted line through all outputs, holding each for DWELL cycles.
module decoder_scan_nx2n #(
  parameter int unsigned N     = 3,
  parameter int unsigned DWELL = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                mode,
  input  logic [N-1:0]        x1,
  input  logic                load,
  output logic [(1<<N)-1:0]   y1,
  output logic [N-1:0]        idx,
  output logic                wrap
);

  localparam int unsigned W  = 1 << N;
  localparam int unsigned CW = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic [1:0] {
    IDLE,
    DIRECT,
    SCAN
  } state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [N-1:0]    idx_q;
  logic [W-1:0]    y_q;
  logic            wrap_q;

  logic [N-1:0]    idx_d;
  logic            last_line;
  logic            dwell_done;

  assign idx_d      = idx_q + N'(1);
  assign last_line  = (idx_q == N'(W - 1));
  assign dwell_done = (cnt_q == CW'(DWELL - 1));

  // State is chosen fresh from en/mode every edge; scan entry restarts the dwell.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      y_q     <= '0;
      wrap_q  <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (!en) begin
        state_q <= IDLE;
        y_q     <= '0;
      end else if (!mode) begin
        state_q <= DIRECT;
        idx_q   <= x1;
        y_q     <= W'(1) << x1;
        cnt_q   <= '0;
      end else begin
        state_q <= SCAN;
        if (state_q != SCAN) begin
          cnt_q <= '0;
          y_q   <= W'(1) << idx_q;
        end else if (load) begin
          idx_q <= x1;
          cnt_q <= '0;
          y_q   <= W'(1) << x1;
        end else if (dwell_done) begin
          cnt_q  <= '0;
          idx_q  <= idx_d;
          y_q    <= W'(1) << idx_d;
          wrap_q <= last_line;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end
  end

  assign y1   = y_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_decoder_scan_nx2n.sv
// Bench for decoder_scan_nx2n: directed scenarios plus random stimulus on an
// N=3/DWELL=2 and an N=1/DWELL=1 instance, checked against a cycle model.
module tb_decoder_scan_nx2n;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_en, a_mode, a_load;
  logic [2:0] a_x;
  logic [7:0] a_y;
  logic [2:0] a_idx;
  logic       a_wrap;
  logic       b_en, b_mode, b_load;
  logic [0:0] b_x;
  logic [1:0] b_y;
  logic [0:0] b_idx;
  logic       b_wrap;

  int total = 0;
  int bad   = 0;

  int m_idx[2], m_cnt[2], m_y[2], m_wrap[2];
  bit m_scan[2];

  always #5 clk = ~clk;

  decoder_scan_nx2n #(.N(3), .DWELL(2)) u_a (
    .clk(clk), .rst(rst), .en(a_en), .mode(a_mode), .x1(a_x), .load(a_load),
    .y1(a_y), .idx(a_idx), .wrap(a_wrap)
  );

  decoder_scan_nx2n #(.N(1), .DWELL(1)) u_b (
    .clk(clk), .rst(rst), .en(b_en), .mode(b_mode), .x1(b_x), .load(b_load),
    .y1(b_y), .idx(b_idx), .wrap(b_wrap)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=0x%0h exp=0x%0h", tag, $time, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_idx[k] = 0; m_cnt[k] = 0; m_y[k] = 0; m_wrap[k] = 0; m_scan[k] = 0;
    end
  endfunction

  // One clock edge of behaviour for instance k with 2^n lines and dwell d.
  function automatic void model_step(input int k, input int n, input int d,
                                     input bit e, input bit md, input bit ld, input int xv);
    int lines = 1 << n;
    m_wrap[k] = 0;
    if (!e) begin
      m_y[k] = 0; m_scan[k] = 0;
    end else if (!md) begin
      m_idx[k] = xv; m_cnt[k] = 0; m_y[k] = 1 << xv; m_scan[k] = 0;
    end else if (!m_scan[k]) begin
      m_scan[k] = 1; m_cnt[k] = 0; m_y[k] = 1 << m_idx[k];
    end else if (ld) begin
      m_idx[k] = xv; m_cnt[k] = 0; m_y[k] = 1 << xv;
    end else if (m_cnt[k] == d - 1) begin
      m_cnt[k]  = 0;
      m_wrap[k] = (m_idx[k] == lines - 1) ? 1 : 0;
      m_idx[k]  = (m_idx[k] + 1) % lines;
      m_y[k]    = 1 << m_idx[k];
    end else begin
      m_cnt[k]++;
    end
  endfunction

  task automatic check_all(input string ph);
    chk({ph, "_a_y"},    32'(a_y),    32'(m_y[0]));
    chk({ph, "_a_idx"},  32'(a_idx),  32'(m_idx[0]));
    chk({ph, "_a_wrap"}, 32'(a_wrap), 32'(m_wrap[0]));
    chk({ph, "_b_y"},    32'(b_y),    32'(m_y[1]));
    chk({ph, "_b_idx"},  32'(b_idx),  32'(m_idx[1]));
    chk({ph, "_b_wrap"}, 32'(b_wrap), 32'(m_wrap[1]));
  endtask

  task automatic tick(input string ph);
    @(posedge clk);
    model_step(0, 3, 2, a_en, a_mode, a_load, int'(a_x));
    model_step(1, 1, 1, b_en, b_mode, b_load, int'(b_x));
    #1;
    check_all(ph);
  endtask

  task automatic async_reset(input string ph);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all(ph);
    @(negedge clk);
    rst = 1'b0;
  endtask

  int wraps;
  int guard;

  initial begin
    rst = 1'b1;
    a_en = 0; a_mode = 0; a_load = 0; a_x = '0;
    b_en = 1; b_mode = 1; b_load = 0; b_x = '0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // direct decode sweep
    a_en = 1; a_mode = 0;
    for (int i = 0; i < 8; i++) begin
      a_x = 3'(i);
      tick("direct");
      chk("direct_y_const", 32'(a_y), 32'(1) << i);
    end

    // full sweep from line 0, count wrap pulses
    a_x = 3'd0;
    tick("direct0");
    a_mode = 1;
    wraps = 0;
    for (int i = 0; i < 18; i++) begin
      tick("sweep");
      if (a_wrap) begin
        wraps++;
        chk("wrap_on_line0", 32'(a_y), 32'h01);
      end
    end
    chk("sweep_wraps", 32'(wraps), 32'd1);

    // load mid-dwell to line 5
    guard = 0;
    while (m_cnt[0] != 1 && guard < 10) begin tick("preload"); guard++; end
    a_load = 1; a_x = 3'd5;
    tick("load");
    chk("load_y", 32'(a_y), 32'h20);
    a_load = 0;
    tick("load_hold");
    chk("load_hold_y", 32'(a_y), 32'h20);
    tick("load_adv");
    chk("load_adv_y", 32'(a_y), 32'h40);

    // drop enable for three cycles at line 6
    guard = 0;
    while (m_idx[0] != 6 && guard < 40) begin tick("to6"); guard++; end
    chk("reach_idx6", 32'(a_idx), 32'd6);
    a_en = 0;
    for (int i = 0; i < 3; i++) begin
      tick("en_off");
      chk("en_off_y", 32'(a_y), 32'h0);
    end
    a_en = 1;
    tick("reen0"); chk("reen_y0", 32'(a_y), 32'h40);
    tick("reen1"); chk("reen_y1", 32'(a_y), 32'h40);
    tick("reen2"); chk("reen_y2", 32'(a_y), 32'h80);

    // async reset mid-sweep at line 4
    guard = 0;
    while (m_idx[0] != 4 && guard < 40) begin tick("to4"); guard++; end
    chk("reach_idx4", 32'(a_idx), 32'd4);
    async_reset("midrst");
    a_mode = 0; a_x = 3'd2;
    tick("post_rst");
    chk("post_rst_y", 32'(a_y), 32'h04);

    // randomized traffic on both instances
    for (int i = 0; i < 600; i++) begin
      a_en   = ($urandom_range(0, 9) != 0);
      a_mode = ($urandom_range(0, 3) != 0);
      a_load = ($urandom_range(0, 7) == 0);
      a_x    = 3'($urandom_range(0, 7));
      b_en   = ($urandom_range(0, 9) != 0);
      b_mode = ($urandom_range(0, 3) != 0);
      b_load = ($urandom_range(0, 7) == 0);
      b_x    = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 99) == 0) async_reset("rnd_rst");
      tick("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
